sevenseg_capture: RTL and testbench

Monitor and decoder for the multiplexed seven-segment display bus: samples the active-low segment lines {A,B,C,D,E,F,G} and active-low anode strobes, waits for each strobe/segment pattern to settle, and decodes it back to the 4-bit hex value per digit. Sits beside the display driver on the board-level bus. It serves as a self-check readback path for score/lives display logic and as a scoreboard tap for benches.

---
 rtl/sevenseg_capture.sv | 204 ++++++++++++++++++++
 tb/tb_sevenseg_capture.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_capture.sv
`default_nettype none
// ============================================================================
//  Module   : sevenseg_capture
//  Purpose  : Watches a multiplexed, active-low seven-segment bus. Each time
//             one anode/segment pattern has held steady for STABLE_CYCLES
//             samples, it is decoded back to a hex digit.
//             Optional macro: SEVENSEG_CAPTURE_ERR_EN builds the sticky
//             illegal-pattern flag. Without it, err is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module sevenseg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic                    upd_valid,
    output logic [2:0]              upd_idx,
    output logic [3:0]              upd_val,
    output logic                    upd_ok,
    output logic                    frame_done,
    output logic                    err
);

    localparam int c_CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int c_SMP_W = NUM_DIGITS + 7;
    localparam logic [c_CNT_W-1:0]    c_STABLE   = c_CNT_W'(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [NUM_DIGITS-1:0] c_ALL_SEEN = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    logic [c_SMP_W-1:0]      r_s;
    logic [c_CNT_W-1:0]      r_cnt;
    state_t                  r_state;
    logic [4*NUM_DIGITS-1:0] r_digit_val;
    logic [NUM_DIGITS-1:0]   r_digit_ok;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    r_upd_valid;
    logic [2:0]              r_upd_idx;
    logic [3:0]              r_upd_val;
    logic                    r_upd_ok;
    logic                    r_frame_done;

    logic [c_SMP_W-1:0]      w_in;
    logic                    w_same;
    logic                    w_in_valid;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [NUM_DIGITS-1:0]   w_seen_next;
    logic                    w_capture;
    logic [2:0]              w_idx;
    logic [3:0]              w_dec_val;
    logic                    w_dec_ok;

    assign w_in        = {an_n, seg_n};
    assign w_same      = (w_in == r_s);
    assign w_in_valid  = $onehot(~an_n);
    // Captures only happen in TRACK, where the sampled anode is one-hot.
    assign w_sel       = ~r_s[c_SMP_W-1:7];
    assign w_seen_next = r_seen | w_sel;
    assign w_capture   = (r_state == ST_TRACK) && (r_cnt == c_STABLE);

    // Binary index of the selected anode in the sample register
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
                w_idx = i[2:0];
            end
        end
    end

    // Segment pattern (A at bit 6, active-low) back to hex value
    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_val = 4'h0;
        case (r_s[6:0])
            7'b0000001: w_dec_val = 4'h0;
            7'b1001111: w_dec_val = 4'h1;
            7'b0010010: w_dec_val = 4'h2;
            7'b0000110: w_dec_val = 4'h3;
            7'b1001100: w_dec_val = 4'h4;
            7'b0100100: w_dec_val = 4'h5;
            7'b0100000: w_dec_val = 4'h6;
            7'b0001111: w_dec_val = 4'h7;
            7'b0000000: w_dec_val = 4'h8;
            7'b0000100: w_dec_val = 4'h9;
            7'b0001000: w_dec_val = 4'hA;
            7'b1100000: w_dec_val = 4'hB;
            7'b0110001: w_dec_val = 4'hC;
            7'b1000010: w_dec_val = 4'hD;
            7'b0110000: w_dec_val = 4'hE;
            7'b0111000: w_dec_val = 4'hF;
            default:    w_dec_ok  = 1'b0;
        endcase
    end

    // Input sample register and saturating run-length counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s   <= '1;
            r_cnt <= '0;
        end else begin
            r_s <= w_in;
            if (!w_same) begin
                r_cnt <= c_CNT_ONE;
            end else if (r_cnt != c_STABLE) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    // Capture FSM with registered digit table and update pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_digit_val  <= '0;
            r_digit_ok   <= '0;
            r_seen       <= '0;
            r_upd_valid  <= 1'b0;
            r_upd_idx    <= 3'd0;
            r_upd_val    <= 4'h0;
            r_upd_ok     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_upd_valid  <= 1'b0;
            r_frame_done <= 1'b0;

            // The capture always uses the stable sample in r_s; a new
            // pattern arriving on the same edge simply starts its own run.
            if (w_capture) begin
                r_upd_valid <= 1'b1;
                r_upd_idx   <= w_idx;
                r_upd_val   <= w_dec_ok ? w_dec_val : 4'h0;
                r_upd_ok    <= w_dec_ok;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (w_sel[i]) begin
                        if (w_dec_ok) begin
                            r_digit_val[4*i +: 4] <= w_dec_val;
                        end
                        r_digit_ok[i] <= w_dec_ok;
                    end
                end
                if (w_seen_next == c_ALL_SEEN) begin
                    r_frame_done <= 1'b1;
                    r_seen       <= '0;
                end else begin
                    r_seen <= w_seen_next;
                end
            end

            case (r_state)
                ST_TRACK: begin
                    if (!w_same) begin
                        r_state <= w_in_valid ? ST_TRACK : ST_IDLE;
                    end else if (w_capture) begin
                        r_state <= ST_HELD;
                    end
                end
                ST_IDLE, ST_HELD: begin
                    if (!w_same) begin
                        r_state <= w_in_valid ? ST_TRACK : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SEVENSEG_CAPTURE_ERR_EN
    logic r_err;

    // Sticky flag: any capture of an illegal pattern sets it until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_capture && !w_dec_ok) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign digit_val  = r_digit_val;
    assign digit_ok   = r_digit_ok;
    assign upd_valid  = r_upd_valid;
    assign upd_idx    = r_upd_idx;
    assign upd_val    = r_upd_val;
    assign upd_ok     = r_upd_ok;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sevenseg_capture
//  Purpose  : Directed self-checking bench for sevenseg_capture
//             (NUM_DIGITS = 4, STABLE_CYCLES = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sevenseg_capture;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] digit_val;
    logic [3:0]  digit_ok;
    logic        upd_valid;
    logic [2:0]  upd_idx;
    logic [3:0]  upd_val;
    logic        upd_ok;
    logic        frame_done;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    logic [3:0] q_idx[$];
    logic [3:0] q_val[$];
    logic       q_ok[$];
    logic       q_fd[$];

    logic [3:0] exp_v [4] = '{4'h3, 4'hA, 4'h0, 4'hF};
    logic       exp_err;

    sevenseg_capture #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .digit_val  (digit_val),
        .digit_ok   (digit_ok),
        .upd_valid  (upd_valid),
        .upd_idx    (upd_idx),
        .upd_val    (upd_val),
        .upd_ok     (upd_ok),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every capture pulse, away from the active edge
    always @(negedge clk) begin
        if (upd_valid) begin
            q_idx.push_back({1'b0, upd_idx});
            q_val.push_back(upd_val);
            q_ok.push_back(upd_ok);
            q_fd.push_back(frame_done);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        q_idx.delete();
        q_val.delete();
        q_ok.delete();
        q_fd.delete();
    endtask

    // Apply a pattern at the current negedge and hold it for n edges
    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_n  = an;
        seg_n = seg;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef SEVENSEG_CAPTURE_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst   = 1'b1;
        an_n  = 4'b1111;
        seg_n = 7'b1111111;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_digit_val", digit_val, 16'h0000);
        check("rst_digit_ok", digit_ok, 4'h0);
        check("rst_upd_valid", upd_valid, 1'b0);
        check("rst_upd_idx", upd_idx, 3'd0);
        check("rst_upd_val", upd_val, 4'h0);
        check("rst_upd_ok", upd_ok, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single digit: code 2 on digit 0, latency of four edges
        an_n  = 4'b1110;
        seg_n = 7'b0010010;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("t1_valid_%0d", k), upd_valid, (k == 5) ? 1'b1 : 1'b0);
            if (k == 5) begin
                check("t1_idx", upd_idx, 3'd0);
                check("t1_val", upd_val, 4'h2);
                check("t1_ok", upd_ok, 1'b1);
                check("t1_digit0", digit_val[3:0], 4'h2);
                check("t1_digit_ok0", digit_ok[0], 1'b1);
            end
        end

        // Scan all four digits: 3, A, 0, F
        clear_log();
        drive(4'b1110, 7'b0000110, 8);
        drive(4'b1101, 7'b0001000, 8);
        drive(4'b1011, 7'b0000001, 8);
        drive(4'b0111, 7'b0111000, 8);
        check("t2_count", q_val.size(), 4);
        for (int i = 0; i < 4 && i < q_val.size(); i++) begin
            check($sformatf("t2_idx_%0d", i), q_idx[i], i);
            check($sformatf("t2_val_%0d", i), q_val[i], exp_v[i]);
            check($sformatf("t2_fd_%0d", i), q_fd[i], (i == 3) ? 1'b1 : 1'b0);
        end
        check("t2_digit_val", digit_val, 16'hF0A3);
        check("t2_digit_ok", digit_ok, 4'hF);

        // Blank on digit 1 is an illegal code
        clear_log();
        drive(4'b1101, 7'b1111111, 8);
        check("t3_count", q_val.size(), 1);
        if (q_val.size() > 0) begin
            check("t3_idx", q_idx[0], 4'd1);
            check("t3_val", q_val[0], 4'h0);
            check("t3_ok", q_ok[0], 1'b0);
        end
        check("t3_digit_ok", digit_ok, 4'b1101);
        check("t3_digit_val", digit_val, 16'hF0A3);
        check("t3_err", err, exp_err);

        // Short glitch between two stable digits, then two anodes low
        clear_log();
        drive(4'b0111, 7'b0100100, 8);
        drive(4'b1110, 7'b1001111, 3);
        drive(4'b1011, 7'b0000100, 8);
        check("t4_count", q_val.size(), 2);
        if (q_val.size() == 2) begin
            check("t4_idx_a", q_idx[0], 4'd3);
            check("t4_val_a", q_val[0], 4'h5);
            check("t4_idx_b", q_idx[1], 4'd2);
            check("t4_val_b", q_val[1], 4'h9);
        end
        check("t4_digit_val", digit_val, 16'h59A3);
        clear_log();
        drive(4'b1100, 7'b0000000, 10);
        check("t4_multi_count", q_val.size(), 0);

        // Reset in the middle of a run on digit 2
        clear_log();
        drive(4'b1011, 7'b0001111, 3);
        rst = 1'b1;
        @(negedge clk);
        check("t5_digit_val", digit_val, 16'h0000);
        check("t5_digit_ok", digit_ok, 4'h0);
        check("t5_upd_valid", upd_valid, 1'b0);
        check("t5_upd_val", upd_val, 4'h0);
        check("t5_err", err, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("t5_valid_%0d", k), upd_valid, (k == 5) ? 1'b1 : 1'b0);
            if (k == 5) begin
                check("t5_idx", upd_idx, 3'd2);
                check("t5_val", upd_val, 4'h7);
            end
        end
        #1;
        check("t5_count", q_val.size(), 1);
        check("t5_digit_val", digit_val, 16'h0700);

        // Long hold gives one capture; a segment-only change gives another
        clear_log();
        drive(4'b1101, 7'b0110001, 1000);
        check("t6_long_count", q_val.size(), 1);
        if (q_val.size() > 0) begin
            check("t6_long_val", q_val[0], 4'hC);
        end
        clear_log();
        drive(4'b1101, 7'b1000010, 8);
        check("t6_chg_count", q_val.size(), 1);
        if (q_val.size() > 0) begin
            check("t6_chg_idx", q_idx[0], 4'd1);
            check("t6_chg_val", q_val[0], 4'hD);
        end
        check("t6_digit_val", digit_val, 16'h07D0);
        check("t6_err", err, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
